// File: rtl/delay_nu_sync.sv
// Per-channel request delay with a runtime-selectable tap, 1..MAX_U clock units.
// A new tap is accepted only while the channel is quiescent, so in-flight edges never reorder.
module delay_nu_sync #(
  parameter int unsigned CH    = 4,
  parameter int unsigned MAX_U = 16,
  parameter int unsigned DEF_U = 2,
  parameter int unsigned DW    = $clog2(MAX_U + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      inR,
  input  logic [CH*DW-1:0]   dly_sel,
  input  logic               err_clr,
  output logic [CH-1:0]      outR,
  output logic [CH-1:0]      busy,
  output logic [CH-1:0]      cfg_err
);

  localparam int unsigned IW = $clog2(MAX_U);

  // Map a requested delay onto the legal range 1..MAX_U.
  function automatic logic [DW-1:0] clamp_sel(input logic [DW-1:0] v);
    if (v == '0) begin
      return DW'(1);
    end else if (32'(v) > MAX_U) begin
      return DW'(MAX_U);
    end else begin
      return v;
    end
  endfunction

  for (genvar c = 0; c < int'(CH); c++) begin : g_ch
    logic [MAX_U-1:0] sreg;
    logic [DW-1:0]    tap;
    logic [DW-1:0]    shadow;
    logic [DW-1:0]    field;
    logic [IW-1:0]    tap_idx;
    logic             idle;
    logic             err;

    assign field   = dly_sel[c*DW +: DW];
    // Quiescent when every stage already holds the level now on the input.
    assign idle    = (sreg == {MAX_U{inR[c]}});
    assign tap_idx = IW'(tap - DW'(1));

    assign busy[c]    = ~idle;
    assign outR[c]    = sreg[tap_idx];
    assign cfg_err[c] = err;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sreg   <= '0;
        tap    <= DW'(DEF_U);
        shadow <= '0;
        err    <= 1'b0;
      end else begin
        sreg   <= {sreg[MAX_U-2:0], inR[c]};
        shadow <= field;
        if (idle) begin
          tap <= clamp_sel(field);
        end
        // Clear takes priority over a coincident set.
        if (err_clr) begin
          err <= 1'b0;
        end else if (!idle && (field != shadow)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_nu_sync.sv
// Self-checking bench for delay_nu_sync: sample-history reference model, latency table,
// directed corner sequences and randomized traffic.
module tb_delay_nu_sync;

  localparam int unsigned CH    = 4;
  localparam int unsigned MAX_U = 16;
  localparam int unsigned DEF_U = 2;
  localparam int unsigned DW    = $clog2(MAX_U + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     inR;
  logic [CH*DW-1:0]  dly_sel;
  logic              err_clr;
  logic [CH-1:0]     outR;
  logic [CH-1:0]     busy;
  logic [CH-1:0]     cfg_err;

  always #5 clk = ~clk;

  delay_nu_sync #(.CH(CH), .MAX_U(MAX_U), .DEF_U(DEF_U), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .inR     (inR),
    .dly_sel (dly_sel),
    .err_clr (err_clr),
    .outR    (outR),
    .busy    (busy),
    .cfg_err (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of sampled input levels, newest first.
  bit          hist [CH][$];
  int unsigned m_tap [CH];
  int unsigned m_sh  [CH];
  bit          m_err [CH];

  typedef struct {
    int sel;
    int lat;
  } lat_vec_t;

  function automatic int unsigned field_of(input int c);
    return 32'(dly_sel[c*DW +: DW]);
  endfunction

  function automatic int unsigned clamp_ref(input int unsigned v);
    if (v == 0) return 1;
    if (v > MAX_U) return MAX_U;
    return v;
  endfunction

  // Level sampled i edges before the most recent one; before reset everything reads as 0.
  function automatic bit sample_ago(input int c, input int i);
    if (i < hist[c].size()) return hist[c][i];
    return 1'b0;
  endfunction

  function automatic bit m_idle(input int c);
    for (int i = 0; i < int'(MAX_U); i++)
      if (sample_ago(c, i) != inR[c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_out(input int c);
    return sample_ago(c, int'(m_tap[c]) - 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < int'(CH); c++) begin
      hist[c].delete();
      m_tap[c] = DEF_U;
      m_sh[c]  = 0;
      m_err[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < int'(CH); c++) begin
      bit          idle;
      int unsigned f;
      idle = m_idle(c);
      f    = field_of(c);
      if (err_clr) m_err[c] = 1'b0;
      else if (!idle && f != m_sh[c]) m_err[c] = 1'b1;
      m_sh[c] = f;
      if (idle) m_tap[c] = clamp_ref(f);
      hist[c].push_front(inR[c]);
      if (hist[c].size() > int'(MAX_U) + 4) void'(hist[c].pop_back());
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] eo, eb, ee;
    for (int c = 0; c < int'(CH); c++) begin
      eo[c] = m_out(c);
      eb[c] = ~m_idle(c);
      ee[c] = m_err[c];
    end
    check("model_outR", 32'(outR), 32'(eo));
    check("model_busy", 32'(busy), 32'(eb));
    check("model_cfg_err", 32'(cfg_err), 32'(ee));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic settle();
    repeat (MAX_U + 1) tick();
  endtask

  task automatic set_sel(input int c, input int v);
    dly_sel[c*DW +: DW] = DW'(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    lat_vec_t    lat_tab [7];
    logic [7:0]  pat;
    int          meas;

    lat_tab[0] = '{sel: 0,  lat: 1};
    lat_tab[1] = '{sel: 1,  lat: 1};
    lat_tab[2] = '{sel: 2,  lat: 2};
    lat_tab[3] = '{sel: 5,  lat: 5};
    lat_tab[4] = '{sel: 16, lat: 16};
    lat_tab[5] = '{sel: 17, lat: 16};
    lat_tab[6] = '{sel: 31, lat: 16};

    rst = 1'b0; inR = '0; dly_sel = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check("reset_outR", 32'(outR), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cfg_err", 32'(cfg_err), 32'h0);
    rst = 1'b1;

    // Event sampled at the first edge after reset uses the default tap.
    inR[0] = 1'b1;
    tick();
    check("def_outR0_edge1", 32'(outR[0]), 32'h0);
    tick();
    check("def_outR0_edge2", 32'(outR[0]), 32'h1);
    repeat (13) tick();
    check("def_busy0_edge15", 32'(busy[0]), 32'h1);
    tick();
    check("def_busy0_edge16", 32'(busy[0]), 32'h0);
    inR[0] = 1'b0;
    settle();

    // Programmed delay 5, 10-cycle pulse on channel 1.
    set_sel(1, 5);
    tick();
    inR[1] = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      if (k == 9) inR[1] = 1'b0;
      check($sformatf("prog5_k%0d", k), 32'(outR[1]), (k >= 4 && k <= 13) ? 32'h1 : 32'h0);
    end
    settle();

    // Latency table including clamp cases.
    foreach (lat_tab[i]) begin
      set_sel(1, lat_tab[i].sel);
      tick();
      inR[1] = 1'b1;
      meas = -1;
      for (int k = 0; k < int'(MAX_U) + 4; k++) begin
        tick();
        if (outR[1] && meas < 0) meas = k + 1;
      end
      check($sformatf("latency_sel%0d", lat_tab[i].sel), 32'(meas), 32'(lat_tab[i].lat));
      inR[1] = 1'b0;
      settle();
    end

    // Change of selection while busy on channel 2.
    set_sel(2, 3);
    tick();
    inR[2] = 1'b1;
    tick();
    check("busychg_k0", 32'(outR[2]), 32'h0);
    tick();
    check("busychg_k1", 32'(outR[2]), 32'h0);
    set_sel(2, 7);
    tick();
    check("busychg_k2_outR", 32'(outR[2]), 32'h1);
    check("busychg_err_set", 32'(cfg_err[2]), 32'h1);
    settle();
    check("busychg_err_sticky", 32'(cfg_err[2]), 32'h1);
    inR[2] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) check("newtap7_k5", 32'(outR[2]), 32'h1);
      if (k == 6) check("newtap7_k6", 32'(outR[2]), 32'h0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(cfg_err[2]), 32'h0);
    settle();

    // Back-to-back toggles on a 16-deep channel, with channel 0 at tap 1 left idle.
    set_sel(0, 1);
    set_sel(3, 16);
    tick();
    pat = 8'b0101_0101;
    for (int i = 0; i < 8; i++) begin
      inR[3] = pat[i];
      tick();
    end
    inR[3] = 1'b0;
    for (int j = 8; j <= 24; j++) begin
      tick();
      if (j >= 15 && j <= 22)
        check($sformatf("b2b_j%0d", j), 32'(outR[3]), 32'(pat[j-15]));
      check($sformatf("b2b_ch0_j%0d", j), 32'(outR[0]), 32'h0);
    end
    settle();

    // Asynchronous reset while a level is in flight.
    set_sel(1, 4);
    tick();
    inR[1] = 1'b1;
    repeat (6) tick();
    check("pre_rst_outR1", 32'(outR[1]), 32'h1);
    #2;
    inR = '0;
    dly_sel = '0;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_outR", 32'(outR), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    inR[1] = 1'b1;
    tick();
    check("post_rst_k0", 32'(outR[1]), 32'h0);
    tick();
    check("post_rst_k1", 32'(outR[1]), 32'h1);
    inR[1] = 1'b0;
    settle();

    // Randomized traffic against the model.
    repeat (1500) begin
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(99) < 30) inR[c] = ~inR[c];
      if ($urandom_range(99) < 6)
        set_sel(int'($urandom_range(CH - 1)), int'($urandom_range(31)));
      err_clr = ($urandom_range(99) < 3);
      tick();
    end
    err_clr = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
